serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Parametrised serial adder/subtractor. It adds or subtracts WIDTH-bit operands one bit per clock, LSB first, and writes the result back into accumulator register A. Register B rotates, so its contents are preserved after an operation. It extends the original 4-bit serial adder with:
- selectable add/sub mode
- an accumulate option
- a start/busy/done handshake
- carry-out and signed-overflow flags

Parameters:
WIDTH, 4, operand/accumulator width in bits; legal range WIDTH >= 2.
CNT_W, $clog2(WIDTH), width of the bit counter (derived, never overridden).

Ports:
clk  input  1  system clock, rising edge
clear  input  1  synchronous active-high reset
start  input  1  begin operation; sampled only in IDLE or DONE
mode  input  1  0 = A+B, 1 = A-B; latched on accepted start
acc  input  1  1 = keep current A as operand (do not load a_in); latched on start
shift_en  input  1  1 = advance one bit this cycle; 0 = freeze all state while in SHIFT
a_in  input  WIDTH  parallel operand A (loaded when acc=0)
b_in  input  WIDTH  parallel operand B
result  output  WIDTH  contents of register A
b_reg  output  WIDTH  contents of register B
serial_out  output  1  sum bit produced this cycle (0 outside SHIFT)
carry_out  output  1  final carry; in sub mode 1 = no borrow
overflow  output  1  signed overflow = carry into MSB xor carry out
busy  output  1  high in SHIFT
done  output  1  one-cycle pulse in DONE

Behaviour:
- Reset (clear=1 at a rising edge; overrides everything, including mid-operation). Next state is:
  - A=0, B=0, carry FF=0, count=0, state=IDLE
  - busy=0, done=0, carry_out=0, overflow=0
- States: IDLE, SHIFT, DONE.
- Start acceptance (IDLE or DONE, start=1):
  - A<=acc ? A : a_in; B<=b_in
  - carry FF<=mode; mode_reg<=mode; count<=0
  - carry_out and overflow cleared; state<=SHIFT
- Start in SHIFT is ignored.
- IDLE with start=0: hold. DONE with start=0: go to IDLE.
- SHIFT with shift_en=0: no register changes; serial_out=0.
- SHIFT with shift_en=1, per cycle:
  - bx=B[0]^mode_reg
  - s=A[0]^bx^c; cn=majority(A[0],bx,c)
  - A<={s,A[WIDTH-1:1]}; B<={B[0],B[WIDTH-1:1]}; c<=cn
  - serial_out=s (combinational); count<=count+1
- Final SHIFT step (count==WIDTH-1 and shift_en=1):
  - carry_out<=cn; overflow<=c^cn, where c is the carry into the MSB
  - state<=DONE
- Latency: done rises WIDTH+1 edges after the start edge when shift_en is held high. Each shift_en=0 cycle adds one.
- DONE: done=1 and busy=0 for exactly one cycle. result, carry_out and overflow stay stable until the next accepted start or clear.
- Back-to-back: start in DONE is accepted with no IDLE gap. Combined with acc=1 this chains accumulation.
- Subtraction is two's complement: A + ~B + 1 (carry seeded with 1).

Decomposition:
- Package serial_arith_pkg:
  - state_t enum {IDLE, SHIFT, DONE}
  - MODE_ADD=1'b0, MODE_SUB=1'b1
- One sub-module, serial_fa_cell: combinational 1-bit full adder (a, b, cin -> s, cout) with B inversion by mode. The carry FF stays in the parent.

Test Plan:
1. WIDTH=4, add, a_in=0101, b_in=0111, shift_en=1:
   - serial_out sequence 0,0,1,1
   - done at edge 5: result=1100, carry_out=0, overflow=1, b_reg=0111
2. Sub, a_in=0011, b_in=0101:
   - result=1110, carry_out=0 (borrow), overflow=0, b_reg=0101
3. Accumulate from DONE of test 1 (A=1100), start with acc=1, mode=add, b_in=0100 (back-to-back, no IDLE):
   - result=0000, carry_out=1, overflow=0
4. Test 1 with shift_en=0 for 3 cycles after the second shift:
   - done at edge 8, identical result and flags
   - busy held high throughout
5. clear=1 during the third SHIFT cycle:
   - next edge: result=0, b_reg=0, busy=0, carry_out=0, overflow=0
   - done never pulses; new start works normally
6. WIDTH=8, add, 0xFF+0x01:
   - result=0x00, carry_out=1, overflow=0, done at edge 9
   - start asserted during SHIFT is ignored

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder; B is inverted in subtract mode so A - B = A + ~B + 1.
module serial_fa_cell
  import serial_arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic mode,
  output logic s,
  output logic cout
);

  logic bx;

  assign bx   = b ^ (mode == MODE_SUB);
  assign s    = a ^ bx ^ cin;
  assign cout = majority(a, bx, cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, result shifted back into the A register.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             mode,
  input  logic             acc,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] b_reg,
  output logic             serial_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic             mode_reg;
  logic [CNT_W-1:0] count;
  logic             sum_bit;
  logic             carry_nxt;
  logic             accept;
  logic             step;
  logic             last;

  serial_fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry),
    .mode (mode_reg),
    .s    (sum_bit),
    .cout (carry_nxt)
  );

  // Next-state decode plus the per-cycle accept/step/last strobes.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    serial_out = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          step       = 1'b1;
          serial_out = sum_bit;
          if (count == LAST) begin
            last      = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = SHIFT;
          end
        end else begin
          state_nxt = SHIFT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, shift registers, carry and result flags.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      mode_reg  <= MODE_ADD;
      count     <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q       <= acc ? a_q : a_in;
        b_q       <= b_in;
        carry     <= mode;
        mode_reg  <= mode;
        count     <= '0;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
      end else if (step) begin
        a_q   <= {sum_bit, a_q[WIDTH-1:1]};
        b_q   <= {b_q[0], b_q[WIDTH-1:1]};
        carry <= carry_nxt;
        count <= count + CNT_W'(1);
        // carry here is the carry into the MSB on the final step
        if (last) begin
          carry_out <= carry_nxt;
          overflow  <= carry ^ carry_nxt;
        end else begin
          carry_out <= carry_out;
          overflow  <= overflow;
        end
      end else begin
        a_q <= a_q;
      end
    end
  end

  assign result = a_q;
  assign b_reg  = b_q;
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: arithmetic reference model with per-cycle compare plus directed vectors.
module tb_serial_addsub;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       clear, start, mode, acc, shift_en;
  logic [3:0] a_in, b_in, result, b_reg;
  logic       serial_out, carry_out, overflow, busy, done;
  logic       start8;
  logic [7:0] a8, b8, result8, b_reg8;
  logic       serial8, cout8, ovf8, busy8, done8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .clear(clear), .start(start), .mode(mode), .acc(acc), .shift_en(shift_en),
    .a_in(a_in), .b_in(b_in), .result(result), .b_reg(b_reg), .serial_out(serial_out),
    .carry_out(carry_out), .overflow(overflow), .busy(busy), .done(done)
  );

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .clear(clear), .start(start8), .mode(mode), .acc(acc), .shift_en(shift_en),
    .a_in(a8), .b_in(b8), .result(result8), .b_reg(b_reg8), .serial_out(serial8),
    .carry_out(cout8), .overflow(ovf8), .busy(busy8), .done(done8)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int full_sum(input int a, input int b, input logic md);
    return md ? a + ((~b) & MASK) + 1 : a + b;
  endfunction

  function automatic int as_signed(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  function automatic int sgn_ovf(input int a, input int b, input logic md);
    int r;
    r = md ? as_signed(a) - as_signed(b) : as_signed(a) + as_signed(b);
    return (r > (1 << (W - 1)) - 1 || r < -(1 << (W - 1))) ? 1 : 0;
  endfunction

  // Reference model: phase 0 idle, 1 shifting, 2 done; the full answer is known at start.
  bit m_valid = 1'b0;
  int m_phase, m_k, m_a0, m_b0, m_sum, m_sov, m_res, m_b, m_cout, m_ovf;

  always @(posedge clk) begin
    if (clear) begin
      m_valid <= 1'b1;
      m_phase <= 0;
      m_k     <= 0;
      m_res   <= 0;
      m_b     <= 0;
      m_cout  <= 0;
      m_ovf   <= 0;
    end else if (m_valid) begin
      if (m_phase == 1) begin
        if (shift_en) begin
          m_k <= m_k + 1;
          if (m_k == W - 1) begin
            m_phase <= 2;
            m_res   <= m_sum & MASK;
            m_b     <= m_b0;
            m_cout  <= (m_sum >> W) & 1;
            m_ovf   <= m_sov;
          end
        end
      end else if (start) begin
        m_phase <= 1;
        m_k     <= 0;
        m_a0    <= acc ? m_res : int'(a_in);
        m_b0    <= int'(b_in);
        m_sum   <= full_sum(acc ? m_res : int'(a_in), int'(b_in), mode);
        m_sov   <= sgn_ovf(acc ? m_res : int'(a_in), int'(b_in), mode);
        m_cout  <= 0;
        m_ovf   <= 0;
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Per-cycle compare of the 4-bit instance against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      if (m_phase == 1) begin
        check("shift_result", int'(result),
              (((m_sum & ((1 << m_k) - 1)) << (W - m_k)) | (m_a0 >> m_k)) & MASK);
        check("shift_b_reg", int'(b_reg), ((m_b0 >> m_k) | (m_b0 << (W - m_k))) & MASK);
        check("shift_serial", int'(serial_out), shift_en ? ((m_sum >> m_k) & 1) : 0);
        check("shift_busy", int'(busy), 1);
        check("shift_done", int'(done), 0);
        check("shift_flags", int'({carry_out, overflow}), 0);
      end else begin
        check("rest_result", int'(result), m_res);
        check("rest_b_reg", int'(b_reg), m_b);
        check("rest_serial", int'(serial_out), 0);
        check("rest_busy", int'(busy), 0);
        check("rest_done", int'(done), (m_phase == 2) ? 1 : 0);
        check("rest_carry", int'(carry_out), m_cout);
        check("rest_ovf", int'(overflow), m_ovf);
      end
    end
  end

  // Start one 4-bit operation; pat[e] is shift_en for edge e (start edge is edge 1).
  task automatic run_op(input logic md, input logic ac, input logic [3:0] a, input logic [3:0] b,
                        input logic [15:0] pat, output int edge_n, output logic [3:0] seq,
                        output logic busy_ok);
    int ns;
    ns = 0;
    start = 1'b1; mode = md; acc = ac; a_in = a; b_in = b; shift_en = pat[2];
    @(posedge clk);
    edge_n = 1;
    #2 start = 1'b0;
    @(negedge clk);
    seq = 4'b0000;
    busy_ok = 1'b1;
    while (!done && edge_n < 30) begin
      if (!busy) busy_ok = 1'b0;
      if (busy && shift_en && ns < 4) begin
        seq[ns] = serial_out;
        ns++;
      end
      @(posedge clk);
      edge_n++;
      #2 shift_en = (edge_n + 1 < 16) ? pat[edge_n + 1] : 1'b1;
      @(negedge clk);
    end
    shift_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         e;
    logic [3:0] seq;
    logic       bok;
    logic       seen;
    clear = 1'b1; start = 1'b0; start8 = 1'b0; mode = 1'b0; acc = 1'b0; shift_en = 1'b1;
    a_in = 4'd0; b_in = 4'd0; a8 = 8'd0; b8 = 8'd0;
    repeat (2) @(posedge clk);
    #2 clear = 1'b0;
    @(negedge clk);
    check("reset_result", int'(result), 0);
    check("reset_b_reg", int'(b_reg), 0);
    check("reset_busy_done", int'({busy, done}), 0);
    check("reset_flags", int'({carry_out, overflow}), 0);
    check("reset_result8", int'(result8), 0);
    repeat (2) @(posedge clk);
    #2;

    // 5 + 7 = 12, signed overflow
    run_op(1'b0, 1'b0, 4'b0101, 4'b0111, 16'hFFFF, e, seq, bok);
    check("t1_done_edge", e, 5);
    check("t1_serial_seq", int'(seq), 4'b1100);
    check("t1_result", int'(result), 4'b1100);
    check("t1_carry", int'(carry_out), 0);
    check("t1_ovf", int'(overflow), 1);
    check("t1_b_reg", int'(b_reg), 4'b0111);

    // back-to-back accumulate: 12 + 4 wraps to 0; a_in must be ignored
    run_op(1'b0, 1'b1, 4'b1111, 4'b0100, 16'hFFFF, e, seq, bok);
    check("t3_done_edge", e, 5);
    check("t3_result", int'(result), 0);
    check("t3_carry", int'(carry_out), 1);
    check("t3_ovf", int'(overflow), 0);

    @(posedge clk); #2;
    // 3 - 5 = -2 with borrow
    run_op(1'b1, 1'b0, 4'b0011, 4'b0101, 16'hFFFF, e, seq, bok);
    check("t2_done_edge", e, 5);
    check("t2_result", int'(result), 4'b1110);
    check("t2_carry", int'(carry_out), 0);
    check("t2_ovf", int'(overflow), 0);
    check("t2_b_reg", int'(b_reg), 4'b0101);

    repeat (2) @(posedge clk); #2;
    // stall edges 4..6
    run_op(1'b0, 1'b0, 4'b0101, 4'b0111, 16'hFF8F, e, seq, bok);
    check("t4_done_edge", e, 8);
    check("t4_busy_held", int'(bok), 1);
    check("t4_result", int'(result), 4'b1100);
    check("t4_flags", int'({carry_out, overflow}), 2'b01);

    // clear on the third shift edge
    repeat (2) @(posedge clk); #2;
    start = 1'b1; mode = 1'b0; acc = 1'b0; a_in = 4'b0101; b_in = 4'b0111;
    @(posedge clk); #2 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 clear = 1'b1;
    @(posedge clk); #2 clear = 1'b0;
    @(negedge clk);
    check("t5_result", int'(result), 0);
    check("t5_b_reg", int'(b_reg), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_flags", int'({carry_out, overflow}), 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | done;
    end
    check("t5_no_done", int'(seen), 0);
    #1;
    // -7 + -7 overflows and carries
    run_op(1'b0, 1'b0, 4'b1001, 4'b1001, 16'hFFFF, e, seq, bok);
    check("t5_restart_edge", e, 5);
    check("t5_restart_result", int'(result), 4'b0010);
    check("t5_restart_flags", int'({carry_out, overflow}), 2'b11);

    // 8-bit: 0xFF + 0x01 with a spurious start while shifting
    @(posedge clk); #2;
    start8 = 1'b1; mode = 1'b0; acc = 1'b0; a8 = 8'hFF; b8 = 8'h01; shift_en = 1'b1;
    @(posedge clk);
    e = 1;
    #2 start8 = 1'b0;
    @(negedge clk);
    while (!done8 && e < 40) begin
      @(posedge clk);
      e++;
      #2 start8 = (e == 3);
      @(negedge clk);
    end
    start8 = 1'b0;
    check("t6_done_edge", e, 9);
    check("t6_result", int'(result8), 8'h00);
    check("t6_carry", int'(cout8), 1);
    check("t6_ovf", int'(ovf8), 0);
    check("t6_b_reg", int'(b_reg8), 8'h01);
    @(negedge clk);
    check("t6_done_pulse", int'(done8), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
